// File: rtl/alrdwr_mux_rr.sv
// Round-robin arbiter sharing one downstream AL port among SLAVE_COUNT requesters.
// Define ALRDWR_MUX_RD_TIMEOUT_EN to add the stalled-read timeout and late-response drop logic.
module alrdwr_mux_rr #(
  parameter int DATA_BITS           = 2,
  parameter int DATA_WIDTH          = 8 << DATA_BITS,
  parameter int ADDR_WIDTH          = 4,
  parameter int ID_WIDTH            = 1,
  parameter int SLAVE_COUNT         = 2,
  parameter int SLAVE_COUNT_BITS    = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1,
  parameter int RD_OUTSTANDING_BITS = 2,
  parameter int RD_TIMEOUT          = 1023
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0]    sn_al_waddr,
  input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]                sn_al_wdata,
  input  logic [SLAVE_COUNT-1:0]                           sn_al_wvalid,
  input  logic [SLAVE_COUNT*ID_WIDTH-1:0]                  sn_al_wid,
  output logic [SLAVE_COUNT-1:0]                           sn_al_wready,
  input  logic [SLAVE_COUNT*(ADDR_WIDTH-DATA_BITS)-1:0]    sn_al_araddr,
  input  logic [SLAVE_COUNT-1:0]                           sn_al_arvalid,
  input  logic [SLAVE_COUNT*ID_WIDTH-1:0]                  sn_al_arid,
  output logic [SLAVE_COUNT-1:0]                           sn_al_arready,
  output logic [SLAVE_COUNT*DATA_WIDTH-1:0]                sn_al_rdata,
  output logic [SLAVE_COUNT-1:0]                           sn_al_rvalid,
  output logic [SLAVE_COUNT*ID_WIDTH-1:0]                  sn_al_rid,
  input  logic [SLAVE_COUNT-1:0]                           sn_al_rready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0]                  m_al_waddr,
  output logic [DATA_WIDTH-1:0]                            m_al_wdata,
  output logic                                             m_al_wvalid,
  output logic [ID_WIDTH-1:0]                              m_al_wid,
  input  logic                                             m_al_wready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0]                  m_al_araddr,
  output logic                                             m_al_arvalid,
  output logic [ID_WIDTH-1:0]                              m_al_arid,
  input  logic                                             m_al_arready,
  input  logic [DATA_WIDTH-1:0]                            m_al_rdata,
  input  logic                                             m_al_rvalid,
  input  logic [ID_WIDTH-1:0]                              m_al_rid,
  output logic                                             m_al_rready
);

  localparam int AW    = ADDR_WIDTH - DATA_BITS;
  localparam int SB    = SLAVE_COUNT_BITS;
  localparam int OB    = RD_OUTSTANDING_BITS;
  localparam int DEPTH = 1 << OB;
`ifdef ALRDWR_MUX_RD_TIMEOUT_EN
  localparam int EW    = SB + ID_WIDTH;
  localparam int TW    = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
`else
  localparam int EW    = SB;
`endif

  // First requester at or after ptr, wrapping; returns ptr when nobody requests.
  function automatic logic [SB-1:0] rr_pick(input logic [SLAVE_COUNT-1:0] req,
                                            input logic [SB-1:0] ptr);
    logic [SB-1:0] pick;
    int idx;
    pick = ptr;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % SLAVE_COUNT;
      if (req[idx]) pick = idx[SB-1:0];
    end
    return pick;
  endfunction

  function automatic logic [SB-1:0] rr_next(input logic [SB-1:0] g);
    if (int'(g) >= SLAVE_COUNT - 1) return '0;
    return g + 1'b1;
  endfunction

  logic          active;
  logic [SB-1:0] w_ptr, w_own, w_grant;
  logic          w_lock, w_hs;
  logic [SB-1:0] r_ptr, r_own, r_grant;
  logic          r_lock, ar_hs, ar_block;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [OB-1:0] wr_ptr, rd_ptr;
  logic [OB:0]   count;
  logic          fifo_full, fifo_empty, r_pop;
  logic [EW-1:0] head_entry;
  logic [SB-1:0] head_idx;
  logic [EW-1:0] push_entry;

  logic [DATA_WIDTH-1:0] r_data_word;
  logic [ID_WIDTH-1:0]   r_id_word;

  // Outputs stay quiet until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  always_comb begin
    w_grant = w_lock ? w_own : rr_pick(sn_al_wvalid, w_ptr);
  end

  assign m_al_wvalid = active & sn_al_wvalid[w_grant];
  assign m_al_waddr  = sn_al_waddr[w_grant*AW +: AW];
  assign m_al_wdata  = sn_al_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_al_wid    = sn_al_wid[w_grant*ID_WIDTH +: ID_WIDTH];
  assign w_hs        = m_al_wvalid & m_al_wready;

  always_comb begin
    sn_al_wready          = '0;
    sn_al_wready[w_grant] = active & m_al_wready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr  <= '0;
      w_own  <= '0;
      w_lock <= 1'b0;
    end else begin
      w_lock <= m_al_wvalid & ~m_al_wready;
      w_own  <= w_grant;
      if (w_hs) w_ptr <= rr_next(w_grant);
    end
  end

  // A same-cycle pop frees the slot, so a full FIFO still accepts a new read.
  assign ar_block = fifo_full & ~r_pop;

  always_comb begin
    r_grant = r_lock ? r_own : rr_pick(sn_al_arvalid, r_ptr);
  end

  assign m_al_arvalid = active & sn_al_arvalid[r_grant] & ~ar_block;
  assign m_al_araddr  = sn_al_araddr[r_grant*AW +: AW];
  assign m_al_arid    = sn_al_arid[r_grant*ID_WIDTH +: ID_WIDTH];
  assign ar_hs        = m_al_arvalid & m_al_arready;

  always_comb begin
    sn_al_arready          = '0;
    sn_al_arready[r_grant] = active & m_al_arready & ~ar_block;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_own  <= '0;
      r_lock <= 1'b0;
    end else begin
      r_lock <= m_al_arvalid & ~m_al_arready;
      r_own  <= r_grant;
      if (ar_hs) r_ptr <= rr_next(r_grant);
    end
  end

`ifdef ALRDWR_MUX_RD_TIMEOUT_EN
  assign push_entry = {r_grant, m_al_arid};
`else
  assign push_entry = r_grant;
`endif

  assign fifo_full  = (count == (OB+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign head_entry = fifo_mem[rd_ptr];
  assign head_idx   = head_entry[EW-1 -: SB];

  always_ff @(posedge clk) begin
    if (ar_hs) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ar_hs) wr_ptr <= wr_ptr + 1'b1;
      if (r_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({ar_hs, r_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALRDWR_MUX_RD_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;
  logic [OB:0]   drop_cnt;
  logic          tmo_fire, tmo_pop, dropping, drop_dec;

  assign tmo_fire = ~fifo_empty & (tmo_cnt == TW'(RD_TIMEOUT));
  assign tmo_pop  = tmo_fire & sn_al_rready[head_idx];
  assign dropping = (drop_cnt != '0);
  assign drop_dec = dropping & m_al_rvalid;

  // Timed-out heads answer with all-ones; their late downstream responses are swallowed.
  always_comb begin
    sn_al_rvalid = '0;
    m_al_rready  = dropping;
    r_pop        = 1'b0;
    r_data_word  = m_al_rdata;
    r_id_word    = m_al_rid;
    if (tmo_fire) begin
      sn_al_rvalid[head_idx] = 1'b1;
      r_data_word            = '1;
      r_id_word              = head_entry[ID_WIDTH-1:0];
      r_pop                  = sn_al_rready[head_idx];
    end else if (!dropping && !fifo_empty) begin
      sn_al_rvalid[head_idx] = m_al_rvalid;
      m_al_rready            = sn_al_rready[head_idx];
      r_pop                  = m_al_rvalid & sn_al_rready[head_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (r_pop || fifo_empty)            tmo_cnt <= '0;
      else if (tmo_cnt != TW'(RD_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
      case ({tmo_pop, drop_dec})
        2'b10:   drop_cnt <= drop_cnt + 1'b1;
        2'b01:   drop_cnt <= drop_cnt - 1'b1;
        default: drop_cnt <= drop_cnt;
      endcase
    end
  end
`else
  always_comb begin
    sn_al_rvalid = '0;
    m_al_rready  = 1'b0;
    r_pop        = 1'b0;
    r_data_word  = m_al_rdata;
    r_id_word    = m_al_rid;
    if (!fifo_empty) begin
      sn_al_rvalid[head_idx] = m_al_rvalid;
      m_al_rready            = sn_al_rready[head_idx];
      r_pop                  = m_al_rvalid & sn_al_rready[head_idx];
    end
  end
`endif

  assign sn_al_rdata = {SLAVE_COUNT{r_data_word}};
  assign sn_al_rid   = {SLAVE_COUNT{r_id_word}};

endmodule

// File: tb/tb_alrdwr_mux_rr.sv
// Scoreboard bench for alrdwr_mux_rr: stimulus queues expected transfers, negedge monitors check them.
// The timeout section runs only when ALRDWR_MUX_RD_TIMEOUT_EN is defined.
module tb_alrdwr_mux_rr;

  localparam int SC = 2;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic rst_n;

  logic [SC*AW-1:0] sn_al_waddr, sn_al_araddr;
  logic [SC*DW-1:0] sn_al_wdata, sn_al_rdata;
  logic [SC-1:0]    sn_al_wvalid, sn_al_wready, sn_al_arvalid, sn_al_arready;
  logic [SC-1:0]    sn_al_rvalid, sn_al_rready;
  logic [SC*IW-1:0] sn_al_wid, sn_al_arid, sn_al_rid;
  logic [AW-1:0]    m_al_waddr, m_al_araddr;
  logic [DW-1:0]    m_al_wdata, m_al_rdata;
  logic [IW-1:0]    m_al_wid, m_al_arid, m_al_rid;
  logic             m_al_wvalid, m_al_wready, m_al_arvalid, m_al_arready;
  logic             m_al_rvalid, m_al_rready;

  alrdwr_mux_rr #(.RD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .sn_al_waddr(sn_al_waddr), .sn_al_wdata(sn_al_wdata), .sn_al_wvalid(sn_al_wvalid),
    .sn_al_wid(sn_al_wid), .sn_al_wready(sn_al_wready),
    .sn_al_araddr(sn_al_araddr), .sn_al_arvalid(sn_al_arvalid), .sn_al_arid(sn_al_arid),
    .sn_al_arready(sn_al_arready),
    .sn_al_rdata(sn_al_rdata), .sn_al_rvalid(sn_al_rvalid), .sn_al_rid(sn_al_rid),
    .sn_al_rready(sn_al_rready),
    .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
    .m_al_wid(m_al_wid), .m_al_wready(m_al_wready),
    .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid), .m_al_arid(m_al_arid),
    .m_al_arready(m_al_arready),
    .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid), .m_al_rid(m_al_rid),
    .m_al_rready(m_al_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t wq[$];
  exp_t arq[$];
  exp_t rq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input int idx, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [IW-1:0] id);
    exp_t e;
    e.idx  = idx;
    e.addr = addr;
    e.data = data;
    e.id   = id;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives requester k's write and read-address fields (valids are set separately).
  task automatic applyStimulus(input int k, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [IW-1:0] id);
    sn_al_waddr[k*AW +: AW]  = addr;
    sn_al_wdata[k*DW +: DW]  = data;
    sn_al_wid[k*IW +: IW]    = id;
    sn_al_araddr[k*AW +: AW] = addr;
    sn_al_arid[k*IW +: IW]   = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write and read-address monitors: every downstream handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_al_wvalid && m_al_wready) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL w_unexpected: got addr 0x%0h expected no transfer", m_al_waddr);
        end else begin
          mon_e = wq.pop_front();
          checkOutput("w_addr", 64'(m_al_waddr), 64'(mon_e.addr));
          checkOutput("w_data", 64'(m_al_wdata), 64'(mon_e.data));
          checkOutput("w_id", 64'(m_al_wid), 64'(mon_e.id));
          checkOutput("w_grant", 64'(sn_al_wready), 64'(1) << mon_e.idx);
        end
      end
      if (m_al_arvalid && m_al_arready) begin
        if (arq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL ar_unexpected: got addr 0x%0h expected no transfer", m_al_araddr);
        end else begin
          mon_e = arq.pop_front();
          checkOutput("ar_addr", 64'(m_al_araddr), 64'(mon_e.addr));
          checkOutput("ar_id", 64'(m_al_arid), 64'(mon_e.id));
          checkOutput("ar_grant", 64'(sn_al_arready), 64'(1) << mon_e.idx);
        end
      end
    end
  end

  // Read-response monitor: responses must reach requesters in issue order.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < SC; i++) begin
        if (sn_al_rvalid[i] && sn_al_rready[i]) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL r_unexpected: got response at requester %0d expected none", i);
          end else begin
            mon_e = rq.pop_front();
            checkOutput("r_target", 64'(i), 64'(mon_e.idx));
            checkOutput("r_data", 64'(sn_al_rdata[i*DW +: DW]), 64'(mon_e.data));
            checkOutput("r_id", 64'(sn_al_rid[i*IW +: IW]), 64'(mon_e.id));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            rd_req[5];
    logic [IW-1:0] rd_id[5];
    logic [DW-1:0] rd_data[5];
`ifdef ALRDWR_MUX_RD_TIMEOUT_EN
    int waited;
    bit found;
`endif
    rd_req  = '{0, 1, 1, 0, 0};
    rd_id   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rd_data = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004};

    rst_n = 1'b0;
    sn_al_waddr = '0; sn_al_wdata = '0; sn_al_wid = '0; sn_al_araddr = '0; sn_al_arid = '0;
    sn_al_wvalid = '1; sn_al_arvalid = '1; sn_al_rready = '1;
    m_al_wready = 1'b1; m_al_arready = 1'b1; m_al_rvalid = 1'b1;
    m_al_rdata = '0; m_al_rid = '0;

    // Reset state with every input asserted
    #12;
    checkOutput("rst_m_wvalid", 64'(m_al_wvalid), 64'd0);
    checkOutput("rst_m_arvalid", 64'(m_al_arvalid), 64'd0);
    checkOutput("rst_sn_wready", 64'(sn_al_wready), 64'd0);
    checkOutput("rst_sn_arready", 64'(sn_al_arready), 64'd0);
    checkOutput("rst_sn_rvalid", 64'(sn_al_rvalid), 64'd0);
    checkOutput("rst_m_rready", 64'(m_al_rready), 64'd0);
    sn_al_wvalid = '0; sn_al_arvalid = '0; sn_al_rready = '0;
    m_al_wready = 1'b0; m_al_arready = 1'b0; m_al_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Both requesters write back to back: grants alternate 0,1,0,1
    applyStimulus(0, 2'd1, 32'hA0A0_0000, 1'b0);
    applyStimulus(1, 2'd2, 32'hB1B1_0001, 1'b1);
    for (int n = 0; n < 2; n++) begin
      wq.push_back(mk(0, 2'd1, 32'hA0A0_0000, 1'b0));
      wq.push_back(mk(1, 2'd2, 32'hB1B1_0001, 1'b1));
    end
    sn_al_wvalid = 2'b11;
    m_al_wready  = 1'b1;
    repeat (4) tick();
    sn_al_wvalid = '0;
    m_al_wready  = 1'b0;

    // Requester 1 stalled 5 cycles; requester 0 joins but must wait for the lock
    applyStimulus(1, 2'd3, 32'hC1C1_C1C1, 1'b1);
    wq.push_back(mk(1, 2'd3, 32'hC1C1_C1C1, 1'b1));
    wq.push_back(mk(0, 2'd0, 32'hD0D0_D0D0, 1'b0));
    sn_al_wvalid = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        applyStimulus(0, 2'd0, 32'hD0D0_D0D0, 1'b0);
        sn_al_wvalid[0] = 1'b1;
      end
      @(negedge clk);
      checkOutput("w_hold_addr", 64'(m_al_waddr), 64'd3);
      checkOutput("w_hold_data", 64'(m_al_wdata), 64'hC1C1_C1C1);
      checkOutput("w_hold_ready", 64'(sn_al_wready), 64'd0);
      tick();
    end
    m_al_wready = 1'b1;
    tick();
    sn_al_wvalid[1] = 1'b0;
    tick();
    sn_al_wvalid = '0;
    m_al_wready  = 1'b0;

    // Four reads 0,1,1,0 with no response fill the FIFO
    m_al_arready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(rd_req[n], AW'(n), '0, rd_id[n]);
      arq.push_back(mk(rd_req[n], AW'(n), '0, rd_id[n]));
      rq.push_back(mk(rd_req[n], '0, rd_data[n], rd_id[n]));
      sn_al_arvalid = SC'(1) << rd_req[n];
      tick();
    end
    applyStimulus(0, 2'd3, '0, 1'b1);
    arq.push_back(mk(0, 2'd3, '0, 1'b1));
    rq.push_back(mk(0, '0, rd_data[4], rd_id[4]));
    sn_al_arvalid = 2'b01;
    @(negedge clk);
    checkOutput("ar_full_ready", 64'(sn_al_arready), 64'd0);
    checkOutput("ar_full_valid", 64'(m_al_arvalid), 64'd0);
    tick();

    // First response pops while the fifth read pushes in the same cycle
    sn_al_rready = 2'b11;
    m_al_rvalid  = 1'b1;
    m_al_rdata   = rd_data[0];
    m_al_rid     = rd_id[0];
    @(negedge clk);
    checkOutput("pushpop_arready", 64'(sn_al_arready), 64'd1);
    checkOutput("pushpop_rvalid", 64'(sn_al_rvalid), 64'd1);
    checkOutput("pushpop_rready", 64'(m_al_rready), 64'd1);
    tick();
    m_al_rvalid = 1'b0;
    applyStimulus(1, 2'd2, '0, 1'b0);
    sn_al_arvalid = 2'b10;
    @(negedge clk);
    checkOutput("still_full_arready", 64'(sn_al_arready), 64'd0);
    tick();
    sn_al_arvalid = '0;
    for (int n = 1; n < 5; n++) begin
      m_al_rvalid = 1'b1;
      m_al_rdata  = rd_data[n];
      m_al_rid    = rd_id[n];
      tick();
    end

    // Response with nothing outstanding is refused
    m_al_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("empty_rready", 64'(m_al_rready), 64'd0);
    checkOutput("empty_rvalid", 64'(sn_al_rvalid), 64'd0);
    tick();
    m_al_rvalid  = 1'b0;
    m_al_arready = 1'b0;

    // Reset pulsed mid-burst; afterwards requester 0 is granted first
    applyStimulus(0, 2'd1, 32'hE0E0_E0E0, 1'b0);
    applyStimulus(1, 2'd2, 32'hE1E1_E1E1, 1'b1);
    wq.push_back(mk(1, 2'd2, 32'hE1E1_E1E1, 1'b1));
    wq.push_back(mk(0, 2'd1, 32'hE0E0_E0E0, 1'b0));
    sn_al_wvalid  = 2'b11;
    sn_al_arvalid = 2'b11;
    m_al_wready   = 1'b1;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_wvalid", 64'(m_al_wvalid), 64'd0);
    checkOutput("midrst_sn_wready", 64'(sn_al_wready), 64'd0);
    checkOutput("midrst_m_arvalid", 64'(m_al_arvalid), 64'd0);
    checkOutput("midrst_sn_arready", 64'(sn_al_arready), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wq.push_back(mk(0, 2'd1, 32'hE0E0_E0E0, 1'b0));
    tick();
    @(negedge clk);
    checkOutput("postrst_grant", 64'(sn_al_wready), 64'd1);
    tick();
    sn_al_wvalid  = '0;
    sn_al_arvalid = '0;
    m_al_wready   = 1'b0;

`ifdef ALRDWR_MUX_RD_TIMEOUT_EN
    // Unanswered read times out; late response is absorbed; next read is normal
    sn_al_rready = 2'b01;
    m_al_arready = 1'b1;
    applyStimulus(0, 2'd1, '0, 1'b1);
    arq.push_back(mk(0, 2'd1, '0, 1'b1));
    rq.push_back(mk(0, '0, 32'hFFFF_FFFF, 1'b1));
    sn_al_arvalid = 2'b01;
    tick();
    sn_al_arvalid = '0;
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 40) begin
      @(negedge clk);
      if (sn_al_rvalid[0]) found = 1'b1;
      else begin
        @(posedge clk);
        waited++;
      end
    end
    checkOutput("tmo_cycles", 64'(waited), 64'd16);
    tick();
    m_al_rvalid = 1'b1;
    m_al_rdata  = 32'h0000_1234;
    m_al_rid    = 1'b1;
    @(negedge clk);
    checkOutput("drop_rready", 64'(m_al_rready), 64'd1);
    checkOutput("drop_rvalid", 64'(sn_al_rvalid), 64'd0);
    tick();
    m_al_rvalid = 1'b0;
    applyStimulus(0, 2'd2, '0, 1'b0);
    arq.push_back(mk(0, 2'd2, '0, 1'b0));
    rq.push_back(mk(0, '0, 32'h5555_AAAA, 1'b0));
    sn_al_arvalid = 2'b01;
    tick();
    sn_al_arvalid = '0;
    m_al_rvalid   = 1'b1;
    m_al_rdata    = 32'h5555_AAAA;
    m_al_rid      = 1'b0;
    tick();
    m_al_rvalid = 1'b0;
`endif

    // Every queued expectation must have been consumed
    for (int c = 0; c < 50 && (wq.size() + arq.size() + rq.size()) != 0; c++) tick();
    checkOutput("drain_outstanding", 64'(wq.size() + arq.size() + rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
